// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back FIFO driving the register file
// write port from link, load and ALU producers, with a read-side scoreboard.
//
// Ports:
//   clk, rst (sync, active-high), flush   - clock, reset, queue clear
//   wb_en                                 - allow head retire this cycle
//   link_valid/link_pc                    - link write (always to LINK_REG)
//   ld_valid/ld_rd/ld_data                - load write request
//   alu_valid/alu_rd/alu_data             - ALU write request
//   link_ready/ld_ready/alu_ready         - request accepted this cycle
//   RegWr/RW/busW                         - register file write port
//   RA/RB -> hit_a/hit_b, fwd_a/fwd_b     - pending-write lookup
//   count                                 - occupancy
// Optional feature: define WB_BYPASS_EN to return youngest queued data on
// fwd_a/fwd_b; otherwise they are tied to zero.
module regfile_wb_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wb_en,
    input  logic                       link_valid,
    input  logic [31:0]                link_pc,
    input  logic                       ld_valid,
    input  logic [4:0]                 ld_rd,
    input  logic [31:0]                ld_data,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    output logic                       link_ready,
    output logic                       ld_ready,
    output logic                       alu_ready,
    output logic                       RegWr,
    output logic [4:0]                 RW,
    output logic [31:0]                busW,
    input  logic [4:0]                 RA,
    input  logic [4:0]                 RB,
    output logic                       hit_a,
    output logic                       hit_b,
    output logic [31:0]                fwd_a,
    output logic [31:0]                fwd_b,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] valid;
    logic [4:0]       rdQ   [DEPTH];
    logic [31:0]      dataQ [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    countQ;

    logic        headValid;
    logic        space;
    logic        grantOk;
    logic        push;
    logic        pop;
    logic [4:0]  pushRd;
    logic [31:0] pushData;
    logic        hitA;
    logic        hitB;

    assign count     = countQ;
    assign headValid = valid[head];
    assign RegWr     = headValid & wb_en & ~flush & ~rst;
    assign RW        = headValid ? rdQ[head] : 5'd0;
    assign busW      = headValid ? dataQ[head] : 32'd0;
    assign pop       = RegWr;

    // A full queue can still accept when the head leaves on the same edge.
    assign space   = (countQ < CW'(DEPTH)) | RegWr;
    assign grantOk = space & ~flush & ~rst;

    assign link_ready = grantOk & link_valid;
    assign ld_ready   = grantOk & ld_valid & ~link_valid;
    assign alu_ready  = grantOk & alu_valid & ~link_valid & ~ld_valid;

    always_comb begin
        pushRd   = 5'd0;
        pushData = 32'd0;
        unique case (1'b1)
            link_ready: begin
                pushRd   = LINK_REG;
                pushData = link_pc;
            end
            ld_ready: begin
                pushRd   = ld_rd;
                pushData = ld_data;
            end
            alu_ready: begin
                pushRd   = alu_rd;
                pushData = alu_data;
            end
            default: ;
        endcase
    end

    // Writes to r0 are acknowledged but never occupy a slot.
    assign push = (link_ready | ld_ready | alu_ready) & (pushRd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head   <= '0;
            tail   <= '0;
            countQ <= '0;
            valid  <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + AW'(1);
            end
            // Placed after the pop so a same-slot push (full queue) wins.
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + AW'(1);
            end
            if (push && !pop)
                countQ <= countQ + CW'(1);
            else if (pop && !push)
                countQ <= countQ - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rdQ[tail]   <= pushRd;
            dataQ[tail] <= pushData;
        end
    end

    always_comb begin
        hitA = 1'b0;
        hitB = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && rdQ[i] == RA) hitA = 1'b1;
            if (valid[i] && rdQ[i] == RB) hitB = 1'b1;
        end
    end

    assign hit_a = hitA & (RA != 5'd0);
    assign hit_b = hitB & (RB != 5'd0);

`ifdef WB_BYPASS_EN
    logic [31:0]   fwdA;
    logic [31:0]   fwdB;
    logic [AW-1:0] idx;

    // Walk oldest to youngest so the last match is the newest data.
    always_comb begin
        fwdA = 32'd0;
        fwdB = 32'd0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (valid[idx] && rdQ[idx] == RA) fwdA = dataQ[idx];
            if (valid[idx] && rdQ[idx] == RB) fwdB = dataQ[idx];
        end
    end

    assign fwd_a = hit_a ? fwdA : 32'd0;
    assign fwd_b = hit_b ? fwdB : 32'd0;
`else
    assign fwd_a = 32'd0;
    assign fwd_b = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed-vector bench for regfile_wb_queue: one table row per cycle,
// plus a hand-written same-register ordering sequence.
module tb_regfile_wb_queue;

    logic        clk = 1'b0;
    logic        rst, flush, wb_en;
    logic        link_valid, ld_valid, alu_valid;
    logic [31:0] link_pc, ld_data, alu_data;
    logic [4:0]  ld_rd, alu_rd, RA, RB;
    logic        link_ready, ld_ready, alu_ready;
    logic        RegWr;
    logic [4:0]  RW;
    logic [31:0] busW, fwd_a, fwd_b;
    logic        hit_a, hit_b;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(4), .LINK_REG(5'd31)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wb_en(wb_en),
        .link_valid(link_valid), .link_pc(link_pc),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .link_ready(link_ready), .ld_ready(ld_ready), .alu_ready(alu_ready),
        .RegWr(RegWr), .RW(RW), .busW(busW),
        .RA(RA), .RB(RB), .hit_a(hit_a), .hit_b(hit_b),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .count(count)
    );

    // ctl = {rst, flush, wb_en}; vld = {link, ld, alu}
    // rdy = {link_ready, ld_ready, alu_ready, RegWr}; hit = {hit_a, hit_b}
    typedef struct {
        logic [2:0]  ctl;
        logic [2:0]  vld;
        logic [31:0] lpc;
        logic [4:0]  drd;
        logic [31:0] ddat;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [3:0]  rdy;
        logic [4:0]  rw;
        logic [31:0] bw;
        logic [1:0]  hit;
        logic [31:0] fa;
        logic [31:0] fb;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vt [27];

    function automatic logic [31:0] bypassExp(input logic [31:0] v);
`ifdef WB_BYPASS_EN
        return v;
`else
        if (v != 32'h0) return 32'h0;
        return v;
`endif
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h",
                     name, row, act, exp);
        end
    endtask

    task automatic idle();
        link_valid = 1'b0;
        ld_valid   = 1'b0;
        alu_valid  = 1'b0;
        link_pc    = 32'h0;
        ld_rd      = 5'd0;
        ld_data    = 32'h0;
        alu_rd     = 5'd0;
        alu_data   = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{3'b100, 3'b001, 32'h0,  5'd0,  32'h0,  5'd5, 32'h1234, 5'd0,  5'd0, 4'b0000, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[1]  = '{3'b001, 3'b001, 32'h0,  5'd0,  32'h0,  5'd5, 32'h1234, 5'd0,  5'd0, 4'b0010, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[2]  = '{3'b001, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd5,  5'd0, 4'b0001, 5'd5,  32'h1234, 2'b10, 32'h1234, 32'h0,  3'd1};
        vt[3]  = '{3'b001, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd5,  5'd0, 4'b0000, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[4]  = '{3'b001, 3'b111, 32'h40, 5'd3,  32'h33, 5'd4, 32'h44,   5'd0,  5'd0, 4'b1000, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[5]  = '{3'b001, 3'b011, 32'h0,  5'd3,  32'h33, 5'd4, 32'h44,   5'd0,  5'd0, 4'b0101, 5'd31, 32'h40,   2'b00, 32'h0,    32'h0,  3'd1};
        vt[6]  = '{3'b001, 3'b001, 32'h0,  5'd0,  32'h0,  5'd4, 32'h44,   5'd0,  5'd0, 4'b0011, 5'd3,  32'h33,   2'b00, 32'h0,    32'h0,  3'd1};
        vt[7]  = '{3'b001, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd0,  5'd0, 4'b0001, 5'd4,  32'h44,   2'b00, 32'h0,    32'h0,  3'd1};
        vt[8]  = '{3'b001, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd0,  5'd0, 4'b0000, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[9]  = '{3'b000, 3'b001, 32'h0,  5'd0,  32'h0,  5'd1, 32'h11,   5'd0,  5'd0, 4'b0010, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[10] = '{3'b000, 3'b001, 32'h0,  5'd0,  32'h0,  5'd2, 32'h22,   5'd0,  5'd0, 4'b0010, 5'd1,  32'h11,   2'b00, 32'h0,    32'h0,  3'd1};
        vt[11] = '{3'b000, 3'b001, 32'h0,  5'd0,  32'h0,  5'd3, 32'h33,   5'd0,  5'd0, 4'b0010, 5'd1,  32'h11,   2'b00, 32'h0,    32'h0,  3'd2};
        vt[12] = '{3'b000, 3'b001, 32'h0,  5'd0,  32'h0,  5'd6, 32'h66,   5'd0,  5'd0, 4'b0010, 5'd1,  32'h11,   2'b00, 32'h0,    32'h0,  3'd3};
        vt[13] = '{3'b000, 3'b001, 32'h0,  5'd0,  32'h0,  5'd8, 32'h88,   5'd0,  5'd0, 4'b0000, 5'd1,  32'h11,   2'b00, 32'h0,    32'h0,  3'd4};
        vt[14] = '{3'b001, 3'b001, 32'h0,  5'd0,  32'h0,  5'd8, 32'h88,   5'd0,  5'd0, 4'b0011, 5'd1,  32'h11,   2'b00, 32'h0,    32'h0,  3'd4};
        vt[15] = '{3'b000, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd8,  5'd2, 4'b0000, 5'd2,  32'h22,   2'b11, 32'h88,   32'h22, 3'd4};
        vt[16] = '{3'b011, 3'b001, 32'h0,  5'd0,  32'h0,  5'd9, 32'h99,   5'd8,  5'd2, 4'b0000, 5'd2,  32'h22,   2'b11, 32'h88,   32'h22, 3'd4};
        vt[17] = '{3'b001, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd8,  5'd2, 4'b0000, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[18] = '{3'b001, 3'b001, 32'h0,  5'd0,  32'h0,  5'd0, 32'h99,   5'd0,  5'd0, 4'b0010, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[19] = '{3'b001, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd0,  5'd0, 4'b0000, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[20] = '{3'b000, 3'b001, 32'h0,  5'd0,  32'h0,  5'd7, 32'hA,    5'd0,  5'd0, 4'b0010, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};
        vt[21] = '{3'b000, 3'b001, 32'h0,  5'd0,  32'h0,  5'd7, 32'hB,    5'd7,  5'd0, 4'b0010, 5'd7,  32'hA,    2'b10, 32'hA,    32'h0,  3'd1};
        vt[22] = '{3'b000, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd7,  5'd0, 4'b0000, 5'd7,  32'hA,    2'b10, 32'hB,    32'h0,  3'd2};
        vt[23] = '{3'b000, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd0,  5'd0, 4'b0000, 5'd7,  32'hA,    2'b00, 32'h0,    32'h0,  3'd2};
        vt[24] = '{3'b000, 3'b010, 32'h0,  5'd12, 32'hC,  5'd0, 32'h0,    5'd0,  5'd0, 4'b0100, 5'd7,  32'hA,    2'b00, 32'h0,    32'h0,  3'd2};
        vt[25] = '{3'b101, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd12, 5'd7, 4'b0000, 5'd7,  32'hA,    2'b11, 32'hC,    32'hB,  3'd3};
        vt[26] = '{3'b001, 3'b000, 32'h0,  5'd0,  32'h0,  5'd0, 32'h0,    5'd12, 5'd7, 4'b0000, 5'd0,  32'h0,    2'b00, 32'h0,    32'h0,  3'd0};

        rst   = 1'b1;
        flush = 1'b0;
        wb_en = 1'b0;
        RA    = 5'd0;
        RB    = 5'd0;
        idle();
        tick();

        for (int r = 0; r < 27; r++) begin
            {rst, flush, wb_en}              = vt[r].ctl;
            {link_valid, ld_valid, alu_valid} = vt[r].vld;
            link_pc  = vt[r].lpc;
            ld_rd    = vt[r].drd;
            ld_data  = vt[r].ddat;
            alu_rd   = vt[r].ard;
            alu_data = vt[r].adat;
            RA       = vt[r].ra;
            RB       = vt[r].rb;
            #3;
            chk("ready_regwr", r,
                {28'h0, link_ready, ld_ready, alu_ready, RegWr},
                {28'h0, vt[r].rdy});
            chk("RW", r, {27'h0, RW}, {27'h0, vt[r].rw});
            chk("busW", r, busW, vt[r].bw);
            chk("hit", r, {30'h0, hit_a, hit_b}, {30'h0, vt[r].hit});
            chk("fwd_a", r, fwd_a, bypassExp(vt[r].fa));
            chk("fwd_b", r, fwd_b, bypassExp(vt[r].fb));
            chk("count", r, {29'h0, count}, {29'h0, vt[r].cnt});
            tick();
        end

        // Two writes to r9 must retire oldest first; bypass sees newest.
        idle();
        rst       = 1'b0;
        flush     = 1'b0;
        wb_en     = 1'b0;
        RA        = 5'd0;
        RB        = 5'd0;
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h1;
        tick();
        alu_data  = 32'h2;
        tick();
        idle();
        RA = 5'd9;
        #3;
        chk("ord_count", 100, {29'h0, count}, 32'd2);
        chk("ord_hit", 100, {31'h0, hit_a}, 32'd1);
        chk("ord_fwd", 100, fwd_a, bypassExp(32'h2));
        wb_en = 1'b1;
        #1;
        chk("ord_regwr0", 101, {31'h0, RegWr}, 32'd1);
        chk("ord_rw0", 101, {27'h0, RW}, 32'd9);
        chk("ord_busw0", 101, busW, 32'h1);
        tick();
        chk("ord_busw1", 102, busW, 32'h2);
        chk("ord_count1", 102, {29'h0, count}, 32'd1);
        tick();
        chk("ord_regwr2", 103, {31'h0, RegWr}, 32'd0);
        chk("ord_count2", 103, {29'h0, count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue that drives the register file write port (`RegWr`, `RW`, `busW`). It collects write requests from three producers: ALU result, load data, and the jump-and-link return address destined for `$31`. Requests are buffered in a small in-order FIFO and retired one per enabled cycle. It also gives the operand-read side a scoreboard view: pending-write hits and, optionally, youngest-data bypass for the register file read addresses `RA`/`RB`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `LINK_REG`, 5'd31: destination used for link writes.

Ports:
- `clk`, in, 1: clock; all state updates on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: synchronous FIFO clear.
- `wb_en`, in, 1: permits retiring the head entry this cycle.
- `link_valid`, in, 1: link write request.
- `link_pc`, in, 32: link data (PC+4).
- `ld_valid`, in, 1: load write request.
- `ld_rd`, in, 5: load destination.
- `ld_data`, in, 32: load data.
- `alu_valid`, in, 1: ALU write request.
- `alu_rd`, in, 5: ALU destination.
- `alu_data`, in, 32: ALU data.
- `link_ready`, `ld_ready`, `alu_ready`, out, 1 each: request accepted this cycle.
- `RegWr`, out, 1: register file write enable.
- `RW`, out, 5: register file write address.
- `busW`, out, 32: register file write data.
- `RA`, `RB`, in, 5 each: read addresses to check.
- `hit_a`, `hit_b`, out, 1 each: a queued write targets `RA`/`RB`.
- `fwd_a`, `fwd_b`, out, 32 each: youngest queued data for `RA`/`RB`.
- `count`, out, $clog2(DEPTH)+1: current occupancy.

## Operation
- **Head and retire**
  - `RegWr` = head valid & `wb_en`.
  - `RW`/`busW` = head entry fields; they are 0 when the FIFO is empty.
  - Pop happens on the same edge the register file samples `RegWr`.
- **Arbitration**
  - At most one push per cycle, fixed priority link > ld > alu.
  - Only the selected source sees its ready high; losers must hold their request.
- **Space**
  - `space` = (`count` < `DEPTH`) | `RegWr`, i.e. push is allowed when full if a pop happens on the same edge.
  - All readys are 0 when `space` is 0 or `flush` is 1.
- **Zero register**
  - A selected request whose destination is 5'd0 gets ready=1 but is discarded and not enqueued.
  - Link writes always use `LINK_REG`.
- **Scoreboard**
  - `hit_a` = (`RA` != 0) & any valid entry with rd == `RA`. `hit_b` is the same for `RB`.
  - The check covers all valid entries including the head, and is purely combinational.
- **Ordering**
  - Strict FIFO order.
  - Two queued writes to the same register retire oldest first.
- **Flush**
  - Clears the pointers and `count`. `RegWr` is forced 0 that cycle and no push occurs.
- **Reset**
  - Pointers and `count` = 0, all entries invalid.
  - Outputs: `RegWr` = 0, `RW` = 0, `busW` = 0, readys = 0, `hit_*` = 0, `fwd_*` = 0.
  - Reset mid-operation drops all pending writes; none are retired on the reset edge.

## Timing
- Push accepted at edge N (FIFO previously empty) → `RegWr`=1 with that entry during cycle N+1 (given `wb_en`=1) → written at edge N+1.
- Throughput: one push and one pop per cycle.
- `count` updates at the edge: +1 for push only, −1 for pop only, unchanged for both or neither.
- Pointers wrap modulo `DEPTH`.
- `hit_*`/`fwd_*` reflect state after the previous edge. A request arriving this cycle is not visible until the next cycle.
- Priority for the same edge: `rst` > `flush` > push/pop.

## Configuration
- `WB_BYPASS_EN` defined:
  - `fwd_a`/`fwd_b` return the data of the youngest valid entry matching `RA`/`RB`, i.e. the entry nearest the tail.
  - `fwd_*` = 0 when the corresponding `hit_*` = 0.
- Not defined:
  - `fwd_a`/`fwd_b` tied to 0 and no match-priority logic is built.
  - `hit_*` unchanged; consumers must stall on a hit.

## Test plan
- **Single write:** reset, `alu_valid`=1, `alu_rd`=5, `alu_data`=0x1234, `wb_en`=1 → `alu_ready`=1; next cycle `RegWr`=1, `RW`=5, `busW`=0x1234, then `count` back to 0.
- **Arbitration:** `link_valid`, `ld_valid` and `alu_valid` all high in one cycle (`ld_rd`=3, `alu_rd`=4), `link_pc`=0x40 → retire order over three cycles is `RW` 31 (0x40), 3, 4; readys grant one source per cycle.
- **Full and backpressure:** `wb_en`=0, push 4 writes → `count`=4, all readys 0 on the 5th request; raise `wb_en` → push and pop on the same edge, `count` stays 4.
- **Zero register:** `alu_rd`=0 → `alu_ready`=1, `count` unchanged, `RegWr` never asserted.
- **Scoreboard and bypass:** queue r7=0xA then r7=0xB with `wb_en`=0, `RA`=7 → `hit_a`=1, `fwd_a`=0xB with the macro and 0 without; `RA`=0 → `hit_a`=0.
- **Flush and reset mid-stream:** 3 entries queued, `flush`=1 → `count`=0, `RegWr`=0 next cycle. Repeat with `rst` → same result, all outputs 0.
